// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and constants for the video fetch arbiter
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_G = 1'b0,
    OWN_T = 1'b1
  } owner_e;

  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam int         MAX_CONSEC_DEFAULT = 4;

endpackage

// File: rtl/video_fetch_arbiter.sv
// rtl/video_fetch_arbiter.sv - arbitrates graphic/text line fetches onto one AXI read port
// and steers returning beats into the owning line buffer.
module video_fetch_arbiter
  import video_pkg::*;
#(
  parameter int MAX_CONSEC = MAX_CONSEC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        g_req_valid,
  output logic        g_req_ready,
  input  logic [31:0] g_req_addr,
  input  logic [7:0]  g_req_len,
  input  logic [9:0]  g_req_index,
  input  logic        t_req_valid,
  output logic        t_req_ready,
  input  logic [31:0] t_req_addr,
  input  logic [7:0]  t_req_len,
  input  logic [7:0]  t_req_index,
  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  output logic [31:0] axi_ar_payload_addr,
  output logic [7:0]  axi_ar_payload_len,
  output logic [1:0]  axi_ar_payload_burst,
  input  logic        axi_r_valid,
  output logic        axi_r_ready,
  input  logic [31:0] axi_r_payload_data,
  input  logic        axi_r_payload_last,
  output logic        g_wr_en,
  output logic [9:0]  g_wr_index,
  output logic [31:0] g_wr_data,
  output logic        g_done,
  output logic        t_wr_en,
  output logic [7:0]  t_wr_index,
  output logic [31:0] t_wr_data,
  output logic        t_done,
  output logic        busy,
  output logic        err_len
);

  localparam logic [7:0] CONSEC_MAX = 8'(MAX_CONSEC);

  state_e      state_q;
  owner_e      owner_q;
  logic [7:0]  consec_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [9:0]  index_q;
  logic [8:0]  beat_q;
  logic        ar_valid_q;
  logic        g_wr_en_q, t_wr_en_q, g_done_q, t_done_q;
  logic [9:0]  wr_index_q;
  logic [31:0] wr_data_q;
  logic        err_q;
  logic        grant_g, grant_t;

  // Graphic wins by default; text is forced through once graphic has had its streak.
  always_comb begin
    grant_g = 1'b0;
    grant_t = 1'b0;
    if (state_q == ST_IDLE) begin
      if (g_req_valid && !(t_req_valid && consec_q == CONSEC_MAX)) grant_g = 1'b1;
      else if (t_req_valid)                                         grant_t = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_G;
      consec_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      index_q    <= '0;
      beat_q     <= '0;
      ar_valid_q <= 1'b0;
      g_wr_en_q  <= 1'b0;
      t_wr_en_q  <= 1'b0;
      g_done_q   <= 1'b0;
      t_done_q   <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      g_wr_en_q <= 1'b0;
      t_wr_en_q <= 1'b0;
      g_done_q  <= 1'b0;
      t_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_g || grant_t) begin
            owner_q    <= grant_t ? OWN_T : OWN_G;
            addr_q     <= grant_t ? t_req_addr : g_req_addr;
            len_q      <= grant_t ? t_req_len : g_req_len;
            index_q    <= grant_t ? {2'b00, t_req_index} : g_req_index;
            consec_q   <= grant_t ? 8'd0 :
                          (consec_q == CONSEC_MAX) ? consec_q : consec_q + 8'd1;
            beat_q     <= '0;
            ar_valid_q <= 1'b1;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi_ar_ready) begin
            ar_valid_q <= 1'b0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi_r_valid) begin
            g_wr_en_q  <= (owner_q == OWN_G);
            t_wr_en_q  <= (owner_q == OWN_T);
            wr_data_q  <= axi_r_payload_data;
            wr_index_q <= index_q + {1'b0, beat_q};
            if (beat_q != 9'h1FF) beat_q <= beat_q + 9'd1;
            // Only r_last ends the burst; a length mismatch is just flagged.
            if (axi_r_payload_last) begin
              g_done_q <= (owner_q == OWN_G);
              t_done_q <= (owner_q == OWN_T);
              state_q  <= ST_IDLE;
              if (beat_q != {1'b0, len_q}) err_q <= 1'b1;
            end else if (beat_q > {1'b0, len_q}) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign g_req_ready          = grant_g;
  assign t_req_ready          = grant_t;
  assign axi_ar_valid         = ar_valid_q;
  assign axi_ar_payload_addr  = addr_q;
  assign axi_ar_payload_len   = len_q;
  assign axi_ar_payload_burst = AXI_BURST_INCR;
  assign axi_r_ready          = (state_q == ST_DATA);
  assign g_wr_en              = g_wr_en_q;
  assign g_wr_index           = wr_index_q;
  assign g_wr_data            = wr_data_q;
  assign g_done               = g_done_q;
  assign t_wr_en              = t_wr_en_q;
  assign t_wr_index           = wr_index_q[7:0];
  assign t_wr_data            = wr_data_q;
  assign t_done               = t_done_q;
  assign busy                 = (state_q != ST_IDLE);
  assign err_len              = err_q;

endmodule
